apple_eat_ctrl: RTL and testbench

//   Consumer side of the apple-location interface: on every snake move, compares the

---
 rtl/apple_eat_ctrl_pkg.sv | 19 +
 rtl/apple_eat_ctrl_sat.sv | 28 ++
 rtl/apple_eat_ctrl.sv | 140 ++++++++++++++
 tb/tb_apple_eat_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apple_eat_ctrl_pkg.sv
// Shared game constants and types for the snake/apple logic.
// Grid bounds, length limits and apple slot identifiers.
package apple_eat_ctrl_pkg;

    localparam int MAX_LENGTH      = 30;
    localparam int START_LENGTH    = 2;
    localparam int RESPAWN_TIMEOUT = 64;

    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    typedef enum logic {
        APPLE_ONE = 1'b0,
        APPLE_TWO = 1'b1
    } apple_luck_t;

    typedef logic [7:0] apple_loc_t;

endpackage

// File: rtl/apple_eat_ctrl_sat.sv
// Saturating up-counter with synchronous load of its initial value.
// Ports: clk, rst (async high), inc, load -> value (holds at MAX).
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= INIT_V;
        end else if (load) begin
            value <= INIT_V;
        end else if (inc && value != MAX_V) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/apple_eat_ctrl.sv
// Head/apple collision check, respawn confirmation, length and score.
// In: clk, reset, move_tick, head x/y, apple locations, two_apple_en.
// Out: good_collision, eaten_slot, snake_length, score, busy, respawn_err.
module apple_eat_ctrl #(
    parameter int MAX_LENGTH      = apple_eat_ctrl_pkg::MAX_LENGTH,
    parameter int START_LENGTH    = apple_eat_ctrl_pkg::START_LENGTH,
    parameter int RESPAWN_TIMEOUT = apple_eat_ctrl_pkg::RESPAWN_TIMEOUT
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       move_tick,
    input  logic [3:0] snake_head_x,
    input  logic [3:0] snake_head_y,
    input  logic [7:0] apple_location1,
    input  logic [7:0] apple_location2,
    input  logic       two_apple_en,
    output logic       good_collision,
    output logic       eaten_slot,
    output logic [4:0] snake_length,
    output logic [7:0] score,
    output logic       busy,
    output logic       respawn_err
);

    import apple_eat_ctrl_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        EAT,
        WAIT_RESPAWN
    } eat_state_t;

    localparam int TW = $clog2(RESPAWN_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(RESPAWN_TIMEOUT - 1);

    eat_state_t  state, state_nxt;
    apple_loc_t  head_q;
    apple_loc_t  loc_q;
    apple_luck_t slot_q;
    logic        pending_q;
    logic        err_q;
    logic [TW-1:0] tmo_q;

    logic          hit1, hit2;
    logic          take;
    apple_loc_t    sel_loc;
    logic          moved;
    logic [TW-1:0] tmo_inc;

    assign hit1    = head_q == apple_location1;
    assign hit2    = two_apple_en && head_q == apple_location2;
    assign take    = move_tick || pending_q;
    // Slot choice is frozen at CHECK; two_apple_en no longer matters here.
    assign sel_loc = (slot_q == APPLE_TWO) ? apple_location2
                                           : apple_location1;
    assign moved   = sel_loc != loc_q;
    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:
                if (take) state_nxt = CHECK;
            CHECK:
                state_nxt = (hit1 || hit2) ? EAT : IDLE;
            EAT:
                state_nxt = WAIT_RESPAWN;
            WAIT_RESPAWN:
                if (moved || tmo_inc == TMO_LAST) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            head_q    <= '0;
            loc_q     <= '0;
            slot_q    <= APPLE_ONE;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (take) begin
                    head_q    <= {snake_head_y, snake_head_x};
                    pending_q <= 1'b0;
                end
            end else if (move_tick) begin
                // One tick of slack; a second one is an overrun.
                if (pending_q) err_q     <= 1'b1;
                else           pending_q <= 1'b1;
            end
            if (state == CHECK && (hit1 || hit2)) begin
                slot_q <= hit1 ? APPLE_ONE : APPLE_TWO;
                loc_q  <= head_q;
            end
            if (state == EAT) begin
                tmo_q <= '0;
            end
            if (state == WAIT_RESPAWN && !moved) begin
                tmo_q <= tmo_inc;
                if (tmo_inc == TMO_LAST) err_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (5),
        .MAX   (MAX_LENGTH),
        .INIT  (START_LENGTH)
    ) u_length (
        .clk   (system_clk),
        .rst   (reset),
        .inc   (state == EAT),
        .load  (1'b0),
        .value (snake_length)
    );

    sat_counter #(
        .WIDTH (8),
        .MAX   (255),
        .INIT  (0)
    ) u_score (
        .clk   (system_clk),
        .rst   (reset),
        .inc   (state == EAT),
        .load  (1'b0),
        .value (score)
    );

    assign good_collision = state == EAT;
    assign eaten_slot     = slot_q;
    assign busy           = state != IDLE;
    assign respawn_err    = err_q;

endmodule

// File: tb/tb_apple_eat_ctrl.sv
// Directed bench for apple_eat_ctrl with a cycle model and literal checks.
// Compares all outputs every cycle after reset is released.
module tb_apple_eat_ctrl;

    localparam int MAXL = 30;
    localparam int STL  = 2;
    localparam int RT   = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] hx, hy;
    logic [7:0] a1, a2;
    logic       two;
    logic       gc, slot, busy, err;
    logic [4:0] len;
    logic [7:0] score;

    int n_chk  = 0;
    int n_fail = 0;

    apple_eat_ctrl dut (
        .system_clk      (clk),
        .reset           (rst),
        .move_tick       (tick),
        .snake_head_x    (hx),
        .snake_head_y    (hy),
        .apple_location1 (a1),
        .apple_location2 (a2),
        .two_apple_en    (two),
        .good_collision  (gc),
        .eaten_slot      (slot),
        .snake_length    (len),
        .score           (score),
        .busy            (busy),
        .respawn_err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: a job is accepted from a tick, then lives for a number of
    // cycles (age 0 = head compare, age 1 = pulse, age >= 2 = waiting).
    int   m_len = STL;
    int   m_score = 0;
    bit   m_err = 0;
    bit   m_act = 0;
    bit   m_pend = 0;
    bit   m_slot = 0;
    bit   m_was = 0;
    int   m_age = 0;
    int   m_wait = 0;
    logic [7:0] m_head = '0;
    logic [7:0] m_loc = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_len = STL; m_score = 0; m_err = 0; m_act = 0;
            m_pend = 0; m_slot = 0; m_age = 0; m_wait = 0;
        end else begin
            m_was = m_act;
            if (m_was && tick) begin
                if (m_pend) m_err = 1;
                else        m_pend = 1;
            end
            if (!m_was) begin
                if (tick || m_pend) begin
                    m_act = 1; m_age = 0; m_pend = 0;
                    m_head = {hy, hx};
                end
            end else if (m_age == 0) begin
                if (m_head == a1) begin
                    m_slot = 0; m_loc = m_head; m_age = 1;
                end else if (two && m_head == a2) begin
                    m_slot = 1; m_loc = m_head; m_age = 1;
                end else begin
                    m_act = 0;
                end
            end else if (m_age == 1) begin
                m_len   = (m_len < MAXL) ? m_len + 1 : MAXL;
                m_score = (m_score < 255) ? m_score + 1 : 255;
                m_age = 2; m_wait = 0;
            end else begin
                if ((m_slot ? a2 : a1) != m_loc) begin
                    m_act = 0;
                end else begin
                    m_wait++;
                    if (m_wait == RT - 1) begin
                        m_err = 1; m_act = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            chk("gc", gc, int'(m_act && m_age == 1));
            chk("busy", busy, int'(m_act));
            chk("len", len, m_len);
            chk("score", score, m_score);
            chk("err", err, int'(m_err));
            if (m_act && m_age == 1) chk("slot", slot, int'(m_slot));
        end
    end

    task automatic do_tick(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        hx = x; hy = y; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_len", len, STL);
        chk("rst_score", score, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_gc", gc, 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; hx = '0; hy = '0;
        a1 = 8'h00; a2 = 8'h00; two = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t1_len0", len, 2);
        chk("t1_score0", score, 0);
        chk("t1_busy0", busy, 0);

        // 1: single apple eaten, respawn seen
        a1 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t1_gc", gc, 1);
        chk("t1_slot", slot, 0);
        a1 = 8'hA2;
        repeat (2) @(negedge clk);
        chk("t1_busy", busy, 0);
        chk("t1_len", len, 3);
        chk("t1_score", score, 1);

        // 2: apple2 eaten; only apple2 moving releases the wait
        two = 1'b1; a1 = 8'h11; a2 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t2_gc", gc, 1);
        chk("t2_slot", slot, 1);
        a1 = 8'h22; two = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_hold", busy, 1);
        a2 = 8'h77;
        @(negedge clk);
        chk("t2_rel", busy, 0);
        chk("t2_score", score, 2);

        // 3: both apples on the head: apple1 wins, one pulse
        two = 1'b1; a1 = 8'h53; a2 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t3_gc", gc, 1);
        chk("t3_slot", slot, 0);
        @(negedge clk);
        chk("t3_gc_off", gc, 0);
        a1 = 8'h44;
        @(negedge clk);
        chk("t3_rel", busy, 0);
        chk("t3_score", score, 3);
        chk("t3_len", len, 5);

        // 4: apple never moves -> timeout
        two = 1'b0; a1 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t4_gc", gc, 1);
        repeat (63) @(negedge clk);
        chk("t4_err_pre", err, 0);
        chk("t4_busy_pre", busy, 1);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_idle", busy, 0);

        // 5: ticks during wait: one pending, then overrun
        do_reset();
        a1 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t5_gc", gc, 1);
        do_tick(4'd3, 4'd5);
        chk("t5_pend_err", err, 0);
        do_tick(4'd3, 4'd5);
        chk("t5_ovr_err", err, 1);
        do_tick(4'd3, 4'd5);
        a1 = 8'h99;
        @(negedge clk);
        chk("t5_idle", busy, 0);
        @(negedge clk);
        chk("t5_pend_chk", busy, 1);
        @(negedge clk);
        chk("t5_done", busy, 0);

        // 6: length saturation and reset during EAT
        do_reset();
        for (int i = 0; i < 30; i++) begin
            a1 = 8'h53;
            do_tick(4'd3, 4'd5);
            @(negedge clk);
            a1 = 8'h60;
            repeat (2) @(negedge clk);
            if (i == 27) begin
                chk("t6_len28", len, 30);
                chk("t6_score28", score, 28);
            end
        end
        chk("t6_len_sat", len, 30);
        chk("t6_score30", score, 30);
        a1 = 8'h53;
        do_tick(4'd3, 4'd5);
        @(negedge clk);
        chk("t6_gc", gc, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_gc", gc, 0);
        chk("t6_rst_len", len, 2);
        chk("t6_rst_score", score, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_slot", slot, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_pulse", gc, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
